// File: rtl/frame_scheduler.sv
// frame_scheduler
//
// Sequences one output frame through the post-DFT chain:
// NoteFinder -> LinearVisualizer -> LED driver.
//
// DFT sample-read pulses are decimated into frame triggers. A settle delay separates each
// trigger from the NoteFinder start. Each stage is started only after the previous stage
// reports completion. The LED driver is never restarted while it is still busy.
//
// Triggers that arrive while a frame is in flight are dropped and counted. A per-stage
// watchdog abandons a frame whose stage never completes.
//
// Parameters:
//   SETTLE_DELAY  cycles from trigger to nfStart (>= 1)
//   DIV_WIDTH     width of frameDiv and of the sample counter
//   TIMEOUT       maximum cycles spent in any wait state before abort
//   CNT_WIDTH     width of dropCount
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   enable        allow new frame triggers
//   sampleRead    1-cycle pulse per audio sample consumed by the DFT
//   frameDiv      samples per frame (0 behaves as 1)
//   nfFinished    NoteFinder completion pulse
//   lvDataValid   LinearVisualizer output-valid pulse
//   ledDone       LED driver frame-complete pulse
//   nfStart       1-cycle start pulse to NoteFinder
//   lvStart       1-cycle start pulse to LinearVisualizer
//   ledStart      1-cycle start pulse to the LED driver
//   busy          high whenever state != IDLE
//   ledBusy       LED driver is running a frame
//   timeoutErr    sticky; a watchdog abort has occurred
//   dropCount     saturating count of dropped triggers
//   state         encoded FSM state (debug)
module frame_scheduler #(
    parameter int unsigned SETTLE_DELAY = 4,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned TIMEOUT      = 65535,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sampleRead,
    input  logic [DIV_WIDTH-1:0] frameDiv,
    input  logic                 nfFinished,
    input  logic                 lvDataValid,
    input  logic                 ledDone,
    output logic                 nfStart,
    output logic                 lvStart,
    output logic                 ledStart,
    output logic                 busy,
    output logic                 ledBusy,
    output logic                 timeoutErr,
    output logic [CNT_WIDTH-1:0] dropCount,
    output logic [2:0]           state
);

    localparam int unsigned SetW = (SETTLE_DELAY > 1) ? $clog2(SETTLE_DELAY) : 1;
    localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SetW-1:0]      SettleLoad = SetW'(SETTLE_DELAY - 1);
    localparam logic [WdW-1:0]       WdLast     = WdW'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] DropMax    = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSettle  = 3'd1,
        StNfRun   = 3'd2,
        StLvRun   = 3'd3,
        StLedWait = 3'd4
    } state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] sample_cnt_q;
    logic [SetW-1:0]      settle_q;
    logic [WdW-1:0]       wdog_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic                 nf_start_q;
    logic                 lv_start_q;
    logic                 led_start_q;
    logic                 led_busy_q;
    logic                 timeout_err_q;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 trig;
    logic                 wd_expired;

    // frameDiv == 0 behaves as 1, so every sampleRead is a trigger.
    assign div_eff = (frameDiv == '0) ? DIV_WIDTH'(1) : frameDiv;

    // Using ">=" also fires on the next sample when frameDiv is lowered below the count.
    assign trig = enable && sampleRead && (sample_cnt_q >= (div_eff - DIV_WIDTH'(1)));

    assign wd_expired = (wdog_q == WdLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sample_cnt_q  <= '0;
            settle_q      <= '0;
            wdog_q        <= '0;
            drop_cnt_q    <= '0;
            nf_start_q    <= 1'b0;
            lv_start_q    <= 1'b0;
            led_start_q   <= 1'b0;
            led_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // Start pulses are single-cycle unless re-asserted below.
            nf_start_q  <= 1'b0;
            lv_start_q  <= 1'b0;
            led_start_q <= 1'b0;

            if (!enable) begin
                sample_cnt_q <= '0;
            end else if (sampleRead) begin
                sample_cnt_q <= trig ? '0 : sample_cnt_q + DIV_WIDTH'(1);
            end

            // A trigger is dropped in any non-idle state, including the cycle the FSM
            // is returning to IDLE.
            if (trig && (state_q != StIdle) && (drop_cnt_q != DropMax)) begin
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end

            // ledDone clears ledBusy; a ledStart issued in the same cycle overrides below.
            if (ledDone) begin
                led_busy_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    wdog_q <= '0;
                    if (trig) begin
                        state_q  <= StSettle;
                        settle_q <= SettleLoad;
                    end
                end

                StSettle: begin
                    if (settle_q == '0) begin
                        nf_start_q <= 1'b1;
                        state_q    <= StNfRun;
                        wdog_q     <= '0;
                    end else begin
                        settle_q <= settle_q - SetW'(1);
                    end
                end

                StNfRun: begin
                    if (nfFinished) begin
                        lv_start_q <= 1'b1;
                        state_q    <= StLvRun;
                        wdog_q     <= '0;
                    end else if (wd_expired) begin
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                        wdog_q        <= '0;
                    end else begin
                        wdog_q <= wdog_q + WdW'(1);
                    end
                end

                StLvRun: begin
                    if (lvDataValid) begin
                        wdog_q <= '0;
                        // A ledDone in this cycle frees the driver in time for the new start.
                        if (!led_busy_q || ledDone) begin
                            led_start_q <= 1'b1;
                            led_busy_q  <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            state_q <= StLedWait;
                        end
                    end else if (wd_expired) begin
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                        wdog_q        <= '0;
                    end else begin
                        wdog_q <= wdog_q + WdW'(1);
                    end
                end

                StLedWait: begin
                    if (ledDone) begin
                        led_start_q <= 1'b1;
                        led_busy_q  <= 1'b1;
                        state_q     <= StIdle;
                        wdog_q      <= '0;
                    end else if (wd_expired) begin
                        // A driver that never finishes is presumed dead; release it.
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                        led_busy_q    <= 1'b0;
                        wdog_q        <= '0;
                    end else begin
                        wdog_q <= wdog_q + WdW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

    assign nfStart    = nf_start_q;
    assign lvStart    = lv_start_q;
    assign ledStart   = led_start_q;
    assign busy       = (state_q != StIdle);
    assign ledBusy    = led_busy_q;
    assign timeoutErr = timeout_err_q;
    assign dropCount  = drop_cnt_q;
    assign state      = state_q;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Sequences one ColorChord output frame through the post-DFT chain: NoteFinder, then LinearVisualizer, then the LED driver. It decimates DFT sample-read pulses into frame triggers and inserts a settle delay before NoteFinder starts. It holds each stage's start until the previous stage reports completion and never restarts a busy LED driver. Triggers that arrive while a frame is in flight are dropped and counted; a per-stage watchdog recovers from a stage that never completes.

Parameters:
SETTLE_DELAY, 4, cycles from the trigger to the nfStart pulse (DFT bin settling); must be >= 1
DIV_WIDTH, 8, width of frameDiv and of the sample counter
TIMEOUT, 65535, maximum cycles spent in any wait state before abort
CNT_WIDTH, 16, width of dropCount

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  allow new frame triggers
sampleRead  in  1  1-cycle pulse from the DFT on each audio sample consumed
frameDiv  in  DIV_WIDTH  samples per frame; 0 is treated as 1
nfFinished  in  1  NoteFinder completion pulse
lvDataValid  in  1  LinearVisualizer output-valid pulse
ledDone  in  1  LED driver frame-complete pulse
nfStart  out  1  1-cycle start pulse to NoteFinder
lvStart  out  1  1-cycle start pulse to LinearVisualizer
ledStart  out  1  1-cycle start pulse to LED driver
busy  out  1  high whenever state != IDLE
ledBusy  out  1  LED driver is running a frame
timeoutErr  out  1  sticky flag; a watchdog abort has occurred
dropCount  out  CNT_WIDTH  saturating count of dropped triggers
state  out  3  encoded state, for debug

Behaviour:
- Reset: state=IDLE, all start pulses 0, busy=0, ledBusy=0, timeoutErr=0, dropCount=0, sampleCnt=0, watchdog=0. A reset mid-frame abandons the frame; no pulses are issued in the cycle after rst deasserts.
- Trigger generation:
  - Let D = max(frameDiv,1).
  - While enable=1, each sampleRead increments sampleCnt.
  - trig asserts in the cycle where sampleRead=1 and sampleCnt==D-1; sampleCnt then returns to 0.
  - If sampleCnt >= D (frameDiv lowered on the fly), the next sampleRead asserts trig and clears sampleCnt.
  - While enable=0, sampleCnt is held at 0 and no trig fires. An in-flight frame still completes.
- State encoding: IDLE=0, SETTLE=1, NF_RUN=2, LV_RUN=3, LED_WAIT=4.
- IDLE: on trig, go to SETTLE and load the settle counter with SETTLE_DELAY-1.
- SETTLE: decrement the settle counter each cycle. At 0, assert nfStart the next cycle (registered) and enter NF_RUN.
- NF_RUN: on nfFinished, pulse lvStart the next cycle and enter LV_RUN.
- LV_RUN: on lvDataValid:
  - If ledBusy=0, or ledDone is asserted in the same cycle, pulse ledStart the next cycle and go to IDLE.
  - Otherwise go to LED_WAIT.
- LED_WAIT: on ledDone, pulse ledStart the next cycle and go to IDLE.
- Frame latency with an idle LED driver: nfStart = trig + SETTLE_DELAY + 1 cycles; lvStart = nfFinished + 1; ledStart = lvDataValid + 1.
- Dropped triggers: a trig in any state other than IDLE increments dropCount, saturating at all-ones. A trig in the same cycle the FSM enters IDLE is dropped.
- ledBusy:
  - Set in the cycle ledStart is driven.
  - Cleared on ledDone.
  - If ledStart and ledDone coincide, the set wins (ledBusy=1).
  - ledDone while ledBusy=0 is ignored.
- Stray pulses: nfFinished outside NF_RUN and lvDataValid outside LV_RUN are ignored.
- Watchdog:
  - Clears on every state change.
  - Increments each cycle in NF_RUN, LV_RUN and LED_WAIT.
  - On reaching TIMEOUT: go to IDLE, set timeoutErr, issue no start pulse.
  - A LED_WAIT timeout also clears ledBusy.
- Pulse width: start outputs are never high for 2 consecutive cycles.

Test Plan:
- frameDiv=3, enable=1, sampleRead every 10 cycles, instant nfFinished/lvDataValid -> trig on the 3rd, 6th, 9th… pulse; nfStart exactly 5 cycles after each trig; dropCount=0.
- frameDiv=1, nfFinished delayed 40 cycles, sampleRead every 10 cycles -> exactly 1 frame completes; dropCount=3 after 4 triggers; busy high throughout.
- LED driver busy (ledDone withheld 100 cycles) when lvDataValid arrives -> state=4; ledStart exactly 1 cycle after ledDone; ledBusy stays 1.
- TIMEOUT=50, nfFinished never asserted -> state returns to 0 at 50 cycles in NF_RUN; timeoutErr=1; no lvStart; the next trig starts a new frame normally.
- frameDiv=0 -> every sampleRead is a trigger; enable dropped mid-frame -> that frame completes, and no new nfStart occurs despite 5 further sampleRead pulses.
- Reset asserted in LV_RUN -> next cycle state=0, dropCount=0, ledBusy=0, no stray lvStart/ledStart.
